// File: rtl/cache_ctrl.sv
// Cache controller FSM (IDLE/CHECK/WB/FILL) driving external tag/valid/dirty/data arrays.
// Optional performance counters are built only when CACHE_PERF_EN is defined.
module cache_ctrl #(
  parameter int S_INDEX = 3,
  parameter int S_TAG   = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        mem_address,
  output logic               mem_resp,
  output logic [S_INDEX-1:0] index,
  output logic               array_read,
  output logic               tag_load,
  output logic               valid_load,
  output logic               dirty_load,
  output logic               data_load,
  output logic               valid_in,
  output logic               dirty_in,
  input  logic               hit,
  input  logic               dirty,
  output logic               pmem_read,
  output logic               pmem_write,
  input  logic               pmem_resp,
  output logic               pmem_addr_sel,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_WB    = 2'd2,
    ST_FILL  = 2'd3
  } state_t;

  state_t state_r;
  state_t state_nxt_s;
  logic   req_s;
  logic   wr_s;
  logic   unused_addr_s;

  // A simultaneous read and write is handled as a write.
  assign req_s = mem_read | mem_write;
  assign wr_s  = mem_write;

  assign index         = mem_address[S_INDEX+4:5];
  assign unused_addr_s = ^{mem_address[S_INDEX+5+S_TAG-1:S_INDEX+5], mem_address[4:0]};

  // State register; reset parks the FSM in IDLE, which zeroes every strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_nxt_s   = state_r;
    mem_resp      = 1'b0;
    array_read    = 1'b0;
    tag_load      = 1'b0;
    valid_load    = 1'b0;
    dirty_load    = 1'b0;
    data_load     = 1'b0;
    valid_in      = 1'b0;
    dirty_in      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          state_nxt_s = ST_CHECK;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        array_read = 1'b1;
        if (!req_s) begin
          state_nxt_s = ST_IDLE;
        end else if (hit) begin
          mem_resp = 1'b1;
          if (wr_s) begin
            data_load  = 1'b1;
            dirty_load = 1'b1;
            dirty_in   = 1'b1;
          end else begin
            data_load  = 1'b0;
          end
          state_nxt_s = ST_IDLE;
        end else if (dirty) begin
          state_nxt_s = ST_WB;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_WB: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        array_read    = 1'b1;
        if (pmem_resp) begin
          state_nxt_s = req_s ? ST_FILL : ST_IDLE;
        end else begin
          state_nxt_s = ST_WB;
        end
      end
      ST_FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          tag_load    = 1'b1;
          valid_load  = 1'b1;
          dirty_load  = 1'b1;
          data_load   = 1'b1;
          valid_in    = 1'b1;
          // An abandoned request still lands its line, but is not answered.
          state_nxt_s = req_s ? ST_CHECK : ST_IDLE;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

`ifdef CACHE_PERF_EN
  logic [31:0] hit_count_r;
  logic [31:0] miss_count_r;
  logic        hit_evt_s;
  logic        miss_evt_s;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign hit_evt_s  = mem_resp;
  assign miss_evt_s = (state_r == ST_CHECK) &&
                      ((state_nxt_s == ST_WB) || (state_nxt_s == ST_FILL));

  // Saturating hit/miss counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
    end else begin
      hit_count_r  <= hit_evt_s  ? sat_inc(hit_count_r)  : hit_count_r;
      miss_count_r <= miss_evt_s ? sat_inc(miss_count_r) : miss_count_r;
    end
  end

  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed scenarios plus randomized requests
// against a transaction-level cache model (line state + latency rules).
module tb_cache_ctrl;

  localparam int PH_CH = 0;  // CHECK with hit
  localparam int PH_CM = 1;  // CHECK with miss
  localparam int PH_WB = 2;
  localparam int PH_FL = 3;
`ifdef CACHE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [31:0] mem_address;
  logic        mem_resp;
  logic [2:0]  index;
  logic        array_read, tag_load, valid_load, dirty_load, data_load;
  logic        valid_in, dirty_in;
  logic        hit, dirty;
  logic        pmem_read, pmem_write, pmem_resp, pmem_addr_sel;
  logic [31:0] hit_count, miss_count;
  logic [10:0] outs;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] hits_m, misses_m;

  // Environment arrays, written only through the DUT strobes.
  logic        env_clr;
  logic        env_valid [8];
  logic        env_dirty [8];
  logic [23:0] env_tag   [8];

  // Reference line state, updated from the specified request outcome.
  bit          ref_valid [8];
  bit          ref_dirty [8];
  logic [23:0] ref_tag   [8];

  cache_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_resp(mem_resp), .index(index),
    .array_read(array_read), .tag_load(tag_load), .valid_load(valid_load),
    .dirty_load(dirty_load), .data_load(data_load), .valid_in(valid_in),
    .dirty_in(dirty_in), .hit(hit), .dirty(dirty), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_resp(pmem_resp), .pmem_addr_sel(pmem_addr_sel),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  assign outs = {mem_resp, array_read, tag_load, valid_load, dirty_load, data_load,
                 valid_in, dirty_in, pmem_read, pmem_write, pmem_addr_sel};

  always_comb begin
    hit   = env_valid[mem_address[7:5]] && (env_tag[mem_address[7:5]] == mem_address[31:8]);
    dirty = env_dirty[mem_address[7:5]];
  end

  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < 8; i++) begin
        env_valid[i] <= 1'b0;
        env_dirty[i] <= 1'b0;
        env_tag[i]   <= 24'd0;
      end
    end else begin
      if (tag_load)   env_tag[mem_address[7:5]]   <= mem_address[31:8];
      if (valid_load) env_valid[mem_address[7:5]] <= valid_in;
      if (dirty_load) env_dirty[mem_address[7:5]] <= dirty_in;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Strobe vector expected in each phase of a transaction.
  function automatic logic [10:0] exp_out(input int ph, input bit last, input bit wr);
    logic [10:0] e;
    e = 11'd0;
    case (ph)
      PH_CH: e = {1'b1, 1'b1, 1'b0, 1'b0, wr, wr, 1'b0, wr, 1'b0, 1'b0, 1'b0};
      PH_CM: e = 11'b010_0000_0000;
      PH_WB: e = 11'b010_0000_0011;
      PH_FL: e = {1'b0, 1'b0, last, last, last, last, last, 1'b0, 1'b1, 1'b0, 1'b0};
      default: e = 11'd0;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] sat1(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // One complete CPU request; entered and left 1 time unit after a rising edge.
  task automatic run_req(input logic [31:0] addr, input bit rd, input bit wr,
                         input int m, input int n, input string nm);
    int          ph[$];
    int          idx;
    logic [23:0] tg;
    bit          h, last;
    idx = int'(addr[7:5]);
    tg  = addr[31:8];
    h   = ref_valid[idx] && (ref_tag[idx] == tg);
    if (h) begin
      ph.push_back(PH_CH);
    end else begin
      ph.push_back(PH_CM);
      if (ref_valid[idx] && ref_dirty[idx]) for (int k = 0; k < m; k++) ph.push_back(PH_WB);
      for (int k = 0; k < n; k++) ph.push_back(PH_FL);
      ph.push_back(PH_CH);
    end
    mem_address = addr;
    mem_read    = rd;
    mem_write   = wr;
    pmem_resp   = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk({nm, "_idle"}, {21'd0, outs}, 32'd0);
    chk({nm, "_index"}, {29'd0, index}, {29'd0, addr[7:5]});
    @(posedge clk);
    for (int k = 0; k < ph.size(); k++) begin
      #1;
      last = (k + 1 == ph.size()) || (ph[k+1] != ph[k]);
      if (ph[k] == PH_WB || ph[k] == PH_FL) pmem_resp = last;
      else pmem_resp = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk($sformatf("%s_ph%0d", nm, k), {21'd0, outs}, {21'd0, exp_out(ph[k], last, wr)});
      @(posedge clk);
    end
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pmem_resp = 1'b0;
    ref_valid[idx] = 1'b1;
    ref_tag[idx]   = tg;
    ref_dirty[idx] = h ? (ref_dirty[idx] | wr) : wr;
    hits_m = sat1(hits_m);
    if (!h) misses_m = sat1(misses_m);
    @(negedge clk);
    chk({nm, "_hitcnt"}, hit_count, PERF ? hits_m : 32'd0);
    chk({nm, "_misscnt"}, miss_count, PERF ? misses_m : 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [23:0] tg;
    clk = 1'b0; rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_address = 32'h0000_0040; pmem_resp = 1'b0; env_clr = 1'b1;
    hits_m = 32'd0; misses_m = 32'd0;
    for (int i = 0; i < 8; i++) begin
      ref_valid[i] = 1'b0; ref_dirty[i] = 1'b0; ref_tag[i] = 24'd0;
    end
    #3;
    chk("rst_outs", {21'd0, outs}, 32'd0);
    chk("rst_index", {29'd0, index}, 32'd2);
    chk("rst_hitcnt", hit_count, 32'd0);
    chk("rst_misscnt", miss_count, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    env_clr = 1'b0;
    rst_n   = 1'b1;

    // Clean read miss then hit on the same line, write miss/hit, dirty write miss.
    run_req(32'h0000_0040, 1'b1, 1'b0, 1, 3, "rd_miss");
    run_req(32'h0000_0040, 1'b1, 1'b0, 1, 1, "rd_hit");
    run_req(32'h0000_0060, 1'b0, 1'b1, 1, 1, "wr_miss");
    run_req(32'h0000_0060, 1'b0, 1'b1, 1, 1, "wr_hit");
    run_req(32'h0000_1060, 1'b0, 1'b1, 2, 2, "wr_dirty_miss");
    run_req(32'h0000_1060, 1'b1, 1'b1, 1, 1, "rdwr_both");

    // Request withdrawn during FILL: line lands, no response, back to IDLE.
    mem_address = 32'h0000_00A0; mem_read = 1'b1;
    @(negedge clk); chk("ab_idle", {21'd0, outs}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("ab_check", {21'd0, outs}, {21'd0, exp_out(PH_CM, 1'b0, 1'b0)});
    @(posedge clk); #1; mem_read = 1'b0;
    @(negedge clk); chk("ab_fill1", {21'd0, outs}, {21'd0, exp_out(PH_FL, 1'b0, 1'b0)});
    @(posedge clk); #1; pmem_resp = 1'b1;
    @(negedge clk); chk("ab_fill2", {21'd0, outs}, {21'd0, exp_out(PH_FL, 1'b1, 1'b0)});
    @(posedge clk); #1; pmem_resp = 1'b0;
    ref_valid[5] = 1'b1; ref_tag[5] = 24'd0; ref_dirty[5] = 1'b0;
    misses_m = sat1(misses_m);
    @(negedge clk);
    chk("ab_after", {21'd0, outs}, 32'd0);
    chk("ab_misscnt", miss_count, PERF ? misses_m : 32'd0);
    @(posedge clk); #1;

    // Reset in the second FILL cycle.
    mem_address = 32'h0000_00C0; mem_read = 1'b1;
    @(negedge clk); chk("rf_idle", {21'd0, outs}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("rf_check", {21'd0, outs}, {21'd0, exp_out(PH_CM, 1'b0, 1'b0)});
    @(posedge clk); #1;
    @(negedge clk); chk("rf_fill1", {21'd0, outs}, {21'd0, exp_out(PH_FL, 1'b0, 1'b0)});
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rf_async", {21'd0, outs}, 32'd0);
    mem_read = 1'b0;
    @(negedge clk); chk("rf_held", {21'd0, outs}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    hits_m = 32'd0; misses_m = 32'd0;
    @(negedge clk);
    chk("rf_release", {21'd0, outs}, 32'd0);
    chk("rf_hitcnt", hit_count, 32'd0);
    chk("rf_misscnt", miss_count, 32'd0);
    @(posedge clk); #1;
    run_req(32'h0000_00C0, 1'b1, 1'b0, 1, 2, "rf_refill");

`ifdef CACHE_PERF_EN
    force dut.hit_count_r = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.hit_count_r;
    hits_m = 32'hFFFF_FFFF;
    run_req(32'h0000_00C0, 1'b1, 1'b0, 1, 1, "sat_hit");
`endif

    // Randomized traffic over three tags so hits, clean and dirty misses all occur.
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 2))
        0: tg = 24'h000000;
        1: tg = 24'h000001;
        default: tg = 24'h123456;
      endcase
      a = {tg, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
      if ($urandom_range(0, 2) == 0) begin
        run_req(a, 1'b1, 1'b0, $urandom_range(1, 4), $urandom_range(1, 4), $sformatf("rnd%0d_rd", r));
      end else if ($urandom_range(0, 1) == 0) begin
        run_req(a, 1'b0, 1'b1, $urandom_range(1, 4), $urandom_range(1, 4), $sformatf("rnd%0d_wr", r));
      end else begin
        run_req(a, 1'b1, 1'b1, $urandom_range(1, 4), $urandom_range(1, 4), $sformatf("rnd%0d_rw", r));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
